// File: rtl/pc_stack_unit_if.sv
// rtl/pc_stack_unit_if.sv - request/status bundle between control unit and pc_stack_unit
//
// Purpose: groups the per-cycle request lines from the control unit and the
// program-counter / return-stack status returned by pc_stack_unit.
// Ports (signals):
//   enable, next_instr, jump, cmp_jump, call, ret, abs_mode, target : requests
//   pc, top, sp, stack_empty, stack_full, overflow_err, underflow_err : status
// Modports: master = control unit side, slave = pc_stack_unit side.
interface pc_stack_unit_if #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic              enable;
  logic              next_instr;
  logic              jump;
  logic              cmp_jump;
  logic              call;
  logic              ret;
  logic              abs_mode;
  logic [ADDR_W-1:0] target;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] top;
  logic [SP_W-1:0]   sp;
  logic              stack_empty;
  logic              stack_full;
  logic              overflow_err;
  logic              underflow_err;

  modport master (
    output enable, next_instr, jump, cmp_jump, call, ret, abs_mode, target,
    input  pc, top, sp, stack_empty, stack_full, overflow_err, underflow_err
  );

  modport slave (
    input  enable, next_instr, jump, cmp_jump, call, ret, abs_mode, target,
    output pc, top, sp, stack_empty, stack_full, overflow_err, underflow_err
  );
endinterface

// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter with return-address stack for the fetch stage
//
// Purpose: holds the instruction address and applies one action per enabled
// cycle (advance, ret, call, jump) by fixed priority; calls/rets go through an
// internal return-address stack with sticky overflow/underflow flags.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high; clears pc to RESET_PC and all stack state
//   bus   - pc_stack_unit_if.slave: request lines in, pc/stack status out
module pc_stack_unit #(
  parameter int              ADDR_W      = 11,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                clk,
  input  logic                reset,
  pc_stack_unit_if.slave      bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push_en;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] branch_pc;
  logic [ADDR_W-1:0] top_w;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  push_idx;
  logic              empty_w;
  logic              full_w;

  assign empty_w  = (sp_q == '0);
  assign full_w   = (sp_q == SP_W'(STACK_DEPTH));
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign top_idx  = IDX_W'(sp_q - SP_W'(1));
  assign push_idx = IDX_W'(sp_q);
  assign top_w    = empty_w ? '0 : stack_q[top_idx];

  // Sign-extending an ADDR_W offset to ADDR_W bits is the identity, and the
  // sum wraps modulo 2^ADDR_W, so a plain same-width add gives pc + offset.
  assign branch_pc = bus.abs_mode ? bus.target : (pc_q + bus.target);

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (bus.enable) begin
      if (bus.next_instr) begin
        pc_d = pc_inc;
      end else if (bus.ret) begin
        if (empty_w) begin
          unf_d = 1'b1;
        end else begin
          pc_d = top_w;
          sp_d = sp_q - SP_W'(1);
        end
      end else if (bus.call) begin
        if (full_w) begin
          ovf_d = 1'b1;
        end else begin
          push_en = 1'b1;
          sp_d    = sp_q + SP_W'(1);
          pc_d    = branch_pc;
        end
      end else if (bus.jump || bus.cmp_jump) begin
        pc_d = branch_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      // Popped entries are left in place; top is selected through sp.
      if (push_en) begin
        stack_q[push_idx] <= pc_inc;
      end
    end
  end

  assign bus.pc            = pc_q;
  assign bus.sp            = sp_q;
  assign bus.top           = top_w;
  assign bus.stack_empty   = empty_w;
  assign bus.stack_full    = full_w;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - directed self-checking bench for pc_stack_unit
module tb_pc_stack_unit;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  pc_stack_unit_if #(.ADDR_W(11), .STACK_DEPTH(4)) bus ();

  pc_stack_unit #(
    .ADDR_W(11),
    .STACK_DEPTH(4),
    .RESET_PC(11'h010)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [10:0] epc, input logic [2:0] esp,
                        input logic [10:0] etop);
    chk({tag, ".pc"},  {21'd0, bus.pc},  {21'd0, epc});
    chk({tag, ".sp"},  {29'd0, bus.sp},  {29'd0, esp});
    chk({tag, ".top"}, {21'd0, bus.top}, {21'd0, etop});
  endtask

  task automatic chk_fl(input string tag, input logic e, input logic f, input logic o,
                        input logic u);
    chk({tag, ".empty"}, {31'd0, bus.stack_empty},   {31'd0, e});
    chk({tag, ".full"},  {31'd0, bus.stack_full},    {31'd0, f});
    chk({tag, ".ovf"},   {31'd0, bus.overflow_err},  {31'd0, o});
    chk({tag, ".unf"},   {31'd0, bus.underflow_err}, {31'd0, u});
  endtask

  task automatic clr();
    bus.next_instr = 1'b0;
    bus.jump       = 1'b0;
    bus.cmp_jump   = 1'b0;
    bus.call       = 1'b0;
    bus.ret        = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump_abs(input logic [10:0] t);
    clr();
    bus.jump = 1'b1; bus.abs_mode = 1'b1; bus.target = t;
    step();
    clr();
  endtask

  task automatic do_call_abs(input logic [10:0] t);
    clr();
    bus.call = 1'b1; bus.abs_mode = 1'b1; bus.target = t;
    step();
    clr();
  endtask

  task automatic do_ret();
    clr();
    bus.ret = 1'b1;
    step();
    clr();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.abs_mode = 1'b0;
    bus.target = '0;
    clr();
    #2;
    chk_st("reset", 11'h010, 3'd0, 11'h000);
    chk_fl("reset", 1'b1, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    reset = 1'b0;

    // sequential advance
    bus.next_instr = 1'b1;
    step(); chk("seq1.pc", {21'd0, bus.pc}, 32'h011);
    step(); chk("seq2.pc", {21'd0, bus.pc}, 32'h012);
    step(); chk_st("seq3", 11'h013, 3'd0, 11'h000);
    chk("seq3.empty", {31'd0, bus.stack_empty}, 32'd1);
    clr();

    // relative jump by -2, then absolute cmp_jump
    bus.jump = 1'b1; bus.abs_mode = 1'b0; bus.target = 11'h7FE;
    step(); chk("reljump.pc", {21'd0, bus.pc}, 32'h011);
    clr();
    bus.cmp_jump = 1'b1; bus.abs_mode = 1'b1; bus.target = 11'h200;
    step(); chk("cmpjump.pc", {21'd0, bus.pc}, 32'h200);
    clr();

    // wrap cases
    do_jump_abs(11'h7FF);
    chk("wrap_pre.pc", {21'd0, bus.pc}, 32'h7FF);
    bus.next_instr = 1'b1;
    step(); chk("wrap_inc.pc", {21'd0, bus.pc}, 32'h000);
    clr();
    do_jump_abs(11'h005);
    bus.jump = 1'b1; bus.abs_mode = 1'b0; bus.target = 11'h7F0;
    step(); chk("wrap_rel.pc", {21'd0, bus.pc}, 32'h7F5);
    clr();

    // call nesting to full, then overflow
    do_jump_abs(11'h100);
    do_call_abs(11'h200); chk_st("call1", 11'h200, 3'd1, 11'h101);
    do_call_abs(11'h300); chk_st("call2", 11'h300, 3'd2, 11'h201);
    do_call_abs(11'h400); chk_st("call3", 11'h400, 3'd3, 11'h301);
    do_call_abs(11'h500); chk_st("call4", 11'h500, 3'd4, 11'h401);
    chk_fl("call4", 1'b0, 1'b1, 1'b0, 1'b0);
    do_call_abs(11'h600); chk_st("call5", 11'h500, 3'd4, 11'h401);
    chk_fl("call5", 1'b0, 1'b1, 1'b1, 1'b0);

    // unwind
    do_ret(); chk_st("ret1", 11'h401, 3'd3, 11'h301);
    do_ret(); chk_st("ret2", 11'h301, 3'd2, 11'h201);
    do_ret(); chk_st("ret3", 11'h201, 3'd1, 11'h101);
    do_ret(); chk_st("ret4", 11'h101, 3'd0, 11'h000);
    chk_fl("ret4", 1'b1, 1'b0, 1'b1, 1'b0);

    // underflow is sticky
    do_ret(); chk_st("unf", 11'h101, 3'd0, 11'h000);
    chk("unf.flag", {31'd0, bus.underflow_err}, 32'd1);
    repeat (5) step();
    chk("unf_sticky.flag", {31'd0, bus.underflow_err}, 32'd1);
    chk("unf_sticky.pc", {21'd0, bus.pc}, 32'h101);

    // next_instr beats call
    bus.next_instr = 1'b1; bus.call = 1'b1; bus.abs_mode = 1'b1; bus.target = 11'h300;
    step(); chk_st("prio", 11'h102, 3'd0, 11'h000);
    clr();

    // enable low blocks a call
    bus.enable = 1'b0; bus.call = 1'b1; bus.abs_mode = 1'b1; bus.target = 11'h300;
    step(); chk_st("en0", 11'h102, 3'd0, 11'h000);
    clr();
    bus.enable = 1'b1;

    // pushed return address wraps; immediate ret returns to it
    do_jump_abs(11'h7FF);
    do_call_abs(11'h050); chk_st("wrapcall", 11'h050, 3'd1, 11'h000);
    do_ret(); chk_st("wrapret", 11'h000, 3'd0, 11'h000);

    // async reset with two entries on the stack
    do_jump_abs(11'h020);
    do_call_abs(11'h200);
    do_call_abs(11'h300);
    chk_st("pre_rst", 11'h300, 3'd2, 11'h201);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_st("async_rst", 11'h010, 3'd0, 11'h000);
    chk_fl("async_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // enable low also blocks error-flag setting
    bus.enable = 1'b0; bus.ret = 1'b1;
    step(); chk("en0_ret.unf", {31'd0, bus.underflow_err}, 32'd0);
    bus.enable = 1'b1;
    step(); chk("en1_ret.unf", {31'd0, bus.underflow_err}, 32'd1);
    chk("en1_ret.pc", {21'd0, bus.pc}, 32'h010);
    clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program-counter unit for the processor fetch stage. It holds the instruction address and supports the following updates:
- sequential advance
- relative or absolute jump
- subroutine call and return, through an internal return-address stack of configurable depth

Stack misuse is reported through sticky error flags. The unit feeds the instruction memory address and is driven by the control unit's one-hot-per-cycle request lines.

## Interface
Parameters:
- ADDR_W, 11, width of pc, target and stack entries (≥ 2)
- STACK_DEPTH, 4, number of return-address entries (≥ 1)
- RESET_PC, 0, value loaded into pc on reset

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- enable  in  1  when 0, all state holds, including flags
- next_instr  in  1  advance pc by 1
- jump  in  1  unconditional branch
- cmp_jump  in  1  comparison-qualified branch, treated identically to jump
- call  in  1  push return address, then branch
- ret  in  1  pop return address into pc
- abs_mode  in  1  1: branch/call target is absolute; 0: target is a signed offset from pc
- target  in  ADDR_W  branch/call target or signed two's-complement offset
- pc  out  ADDR_W  current instruction address (registered)
- top  out  ADDR_W  return address at top of stack; 0 when empty
- sp  out  $clog2(STACK_DEPTH+1)  number of valid stack entries
- stack_empty  out  1  sp == 0 (combinational from sp)
- stack_full  out  1  sp == STACK_DEPTH (combinational from sp)
- overflow_err  out  1  sticky: a call was attempted with the stack full
- underflow_err  out  1  sticky: a ret was attempted with the stack empty

## Operation
- Reset values:
  - pc = RESET_PC; sp = 0; all stack entries = 0; top = 0
  - overflow_err = underflow_err = 0; stack_empty = 1; stack_full = 0
- With enable=1, exactly one action executes per cycle, chosen by fixed priority:
  1. next_instr: pc ← pc + 1
  2. ret:
     - not empty: pc ← top; sp ← sp − 1
     - empty: pc and sp hold; underflow_err ← 1
  3. call:
     - not full: entry[sp] ← pc + 1; sp ← sp + 1; pc ← branch target
     - full: pc, sp and stack hold; overflow_err ← 1
  4. jump | cmp_jump: pc ← branch target
  5. none asserted: pc holds
- Branch target:
  - abs_mode=1: target
  - abs_mode=0: pc + target, with target sign-extended
- Arithmetic: all address math is modulo 2^ADDR_W.
  - pc = 2^ADDR_W − 1 with next_instr wraps to 0.
  - A pushed return address of pc + 1 wraps the same way.
- Lower-priority requests asserted together with a higher one are ignored, with no side effects.
  - Example: next_instr together with call does not push.
- Sticky error flags stay at 1 until reset; the erroring request makes no other state change.
- Popped entries need not be cleared; top always reflects entry[sp−1], or 0 when sp = 0.
- enable=0 blocks every state change, including error-flag setting.

## Timing
- Single clock domain; every output is registered state or pure combinational decode of registered state. No input-to-output combinational path.
- Latency: a request sampled at edge N is visible on pc/sp/top/flags immediately after edge N. Requests issued on consecutive cycles execute back-to-back.
- A ret at edge N following a call at edge N−1 returns to the address pushed at N−1.
- Reset asserted mid-operation clears state asynchronously, without waiting for clk. The first action is taken at the first rising edge after reset deasserts.

## Test plan
- Reset with RESET_PC=0x010; then 3 cycles of next_instr → pc = 0x011, 0x012, 0x013; sp = 0; stack_empty = 1.
- Relative jump: pc=0x013, abs_mode=0, target=0x7FE (−2), jump → pc = 0x011. Then cmp_jump, abs_mode=1, target=0x200 → pc = 0x200.
- Wrap:
  - pc=0x7FF, next_instr → pc = 0x000
  - pc=0x005, abs_mode=0, target=0x7F0 → pc = 0x7F5
- Call/ret nesting, depth 4:
  - From pc=0x100, four calls to absolute 0x200, 0x300, 0x400, 0x500 → sp = 4, stack_full = 1, top = 0x401
  - A fifth call → pc stays 0x500, sp = 4, overflow_err = 1
  - Four rets → pc = 0x401, 0x301, 0x201, 0x101; stack_empty = 1
- Underflow and priority:
  - ret with sp = 0 → pc holds, underflow_err = 1, remains 1 after 5 more cycles
  - next_instr+call together → pc + 1 only, sp unchanged
  - enable=0 with call asserted → no change
- Async reset mid-call-chain: with sp = 2, assert reset between clock edges → pc = RESET_PC, sp = 0, flags 0 before the next clk edge.
